// File: rtl/pc_seq.sv
// pc_seq: multi-phase program counter sequencer with conditional branch decode,
// a LIFO call/return stack, a sticky halt and sticky stack-error flags.
module pc_seq #(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 49,
    parameter int STAGES  = 3,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic [INSTR_W-1:0]        literal,
    input  logic                      Zflag,
    output logic [PC_W-1:0]           PC,
    output logic [$clog2(STAGES)-1:0] phase,
    output logic                      retire,
    output logic                      halted,
    output logic [1:0]                stk_err
);

    localparam int PH_W  = $clog2(STAGES);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [PH_W-1:0]  PH_ZERO  = PH_W'(0);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_ZS    = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

    localparam logic [4:0] OP_BZ   = 5'h10;
    localparam logic [4:0] OP_BNZ  = 5'h11;
    localparam logic [4:0] OP_BRA  = 5'h12;
    localparam logic [4:0] OP_CALL = 5'h13;
    localparam logic [4:0] OP_RET  = 5'h14;
    localparam logic [4:0] OP_HALT = 5'h1F;

    logic [PC_W-1:0]  r_pc;
    logic [PH_W-1:0]  r_phase;
    logic             r_zq;
    logic             r_retire;
    logic             r_halted;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_stack [DEPTH];

    logic [4:0]       w_opcode;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_top;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_update;
    logic             w_z_eff;
    logic             w_full;
    logic             w_empty;
    logic [PC_W-1:0]  w_pc_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_halt;
    logic [1:0]       w_err_set;
    logic [PH_W-1:0]  w_phase_nxt;
    logic             w_unused_lit;

    assign w_opcode     = literal[INSTR_W-1:INSTR_W-5];
    assign w_target     = literal[PC_W-1:0];
    assign w_unused_lit = ^literal[INSTR_W-6:PC_W];
    assign w_pc_inc     = r_pc + PC_ONE;

    assign w_update = !stall && !r_halted && (r_phase == PH_LAST);
    // With STAGES==2 the sample and update phases coincide, so use the live flag.
    assign w_z_eff  = (r_phase == PH_ZS) ? Zflag : r_zq;

    assign w_full   = (r_cnt == CNT_FULL);
    assign w_empty  = (r_cnt == CNT_ZERO);
    assign w_wr_idx = r_cnt[IDX_W-1:0];
    assign w_rd_idx = IDX_W'(r_cnt - CNT_ONE);
    assign w_top    = r_stack[w_rd_idx];

    // Instruction decode: next PC, stack action, halt request and error flags.
    always_comb begin
        w_pc_nxt  = w_pc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_halt    = 1'b0;
        w_err_set = 2'b00;
        case (w_opcode)
            OP_BZ: begin
                if (w_z_eff) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            OP_BNZ: begin
                if (w_z_eff) begin
                    w_pc_nxt = w_pc_inc;
                end else begin
                    w_pc_nxt = w_target;
                end
            end
            OP_BRA: begin
                w_pc_nxt = w_target;
            end
            OP_CALL: begin
                if (!w_full) begin
                    w_push   = 1'b1;
                    w_pc_nxt = w_target;
                end else begin
                    w_err_set = 2'b01;
                    w_pc_nxt  = w_pc_inc;
                end
            end
            OP_RET: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_pc_nxt = w_top;
                end else begin
                    w_err_set = 2'b10;
                    w_pc_nxt  = w_pc_inc;
                end
            end
            OP_HALT: begin
                w_halt   = 1'b1;
                w_pc_nxt = r_pc;
            end
            default: begin
                w_pc_nxt = w_pc_inc;
            end
        endcase
    end

    // Phase sequencing: hold on stall or halt, park at the last phase on HALT.
    always_comb begin
        w_phase_nxt = r_phase;
        if (stall || r_halted) begin
            w_phase_nxt = r_phase;
        end else if (r_phase == PH_LAST) begin
            if (w_halt) begin
                w_phase_nxt = PH_LAST;
            end else begin
                w_phase_nxt = PH_ZERO;
            end
        end else begin
            w_phase_nxt = r_phase + PH_ONE;
        end
    end

    // Architectural state: PC, phase, captured zero flag, status and stack count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_phase  <= PH_ZERO;
            r_zq     <= 1'b0;
            r_retire <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 2'b00;
            r_cnt    <= CNT_ZERO;
        end else begin
            r_retire <= w_update;
            r_phase  <= w_phase_nxt;
            if (!stall && !r_halted && (r_phase == PH_ZS)) begin
                r_zq <= Zflag;
            end
            if (w_update) begin
                r_pc     <= w_pc_nxt;
                r_halted <= w_halt;
                r_err    <= r_err | w_err_set;
                if (w_push) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end else if (w_pop) begin
                    r_cnt <= r_cnt - CNT_ONE;
                end
            end
        end
    end

    // Return-stack storage; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (!rst && w_update && w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign PC      = r_pc;
    assign phase   = r_phase;
    assign retire  = r_retire;
    assign halted  = r_halted;
    assign stk_err = r_err;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: each instruction pushes its expected PC, and
// every retire pulse pops and compares it; directed checks cover the rest.
module tb_pc_seq;

    localparam logic [4:0] OP_BZ   = 5'h10;
    localparam logic [4:0] OP_BNZ  = 5'h11;
    localparam logic [4:0] OP_BRA  = 5'h12;
    localparam logic [4:0] OP_CALL = 5'h13;
    localparam logic [4:0] OP_RET  = 5'h14;
    localparam logic [4:0] OP_HALT = 5'h1F;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [48:0] literal;
    logic        Zflag;
    logic [5:0]  PC;
    logic [1:0]  phase;
    logic        retire;
    logic        halted;
    logic [1:0]  stk_err;

    int          n_vec;
    int          n_err;
    int          n_push;
    int          n_ret;
    logic [5:0]  sb_q [$];
    logic [5:0]  exp_pc;
    logic [5:0]  exp_stk [$];
    logic [1:0]  exp_err;
    logic [5:0]  pc_before;
    logic [4:0]  seq_ops [4];

    pc_seq #(.PC_W(6), .INSTR_W(49), .STAGES(3), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .literal (literal),
        .Zflag   (Zflag),
        .PC      (PC),
        .phase   (phase),
        .retire  (retire),
        .halted  (halted),
        .stk_err (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [48:0] make_lit(input logic [4:0] op, input logic [5:0] tgt);
        logic [63:0] rnd;
        logic [48:0] v;
        rnd = {$urandom(), $urandom()};
        v = rnd[48:0];
        v[48:44] = op;
        v[5:0] = tgt;
        return v;
    endfunction

    // Reference behaviour of one instruction, z is the flag seen at phase 1.
    task automatic model_step(input logic [4:0] op, input logic [5:0] tgt, input logic z);
        logic [5:0] nxt;
        nxt = exp_pc + 6'd1;
        case (op)
            OP_BZ:   exp_pc = z ? tgt : nxt;
            OP_BNZ:  exp_pc = z ? nxt : tgt;
            OP_BRA:  exp_pc = tgt;
            OP_CALL: begin
                if (exp_stk.size() < 4) begin
                    exp_stk.push_back(nxt);
                    exp_pc = tgt;
                end else begin
                    exp_err[0] = 1'b1;
                    exp_pc = nxt;
                end
            end
            OP_RET: begin
                if (exp_stk.size() > 0) begin
                    exp_pc = exp_stk.pop_back();
                end else begin
                    exp_err[1] = 1'b1;
                    exp_pc = nxt;
                end
            end
            OP_HALT: exp_pc = exp_pc;
            default: exp_pc = nxt;
        endcase
    endtask

    task automatic model_reset();
        exp_pc = 6'd0;
        exp_err = 2'b00;
        exp_stk.delete();
    endtask

    task automatic exec(input logic [4:0] op, input logic [5:0] tgt, input logic z1, input logic zo);
        check_val("phase_at_fetch", {30'd0, phase}, 32'd0);
        literal = make_lit(op, tgt);
        model_step(op, tgt, z1);
        sb_q.push_back(exp_pc);
        n_push++;
        for (int p = 0; p < 3; p++) begin
            Zflag = (p == 1) ? z1 : zo;
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard drain: every retire pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (retire) begin
            n_ret++;
            if (sb_q.size() == 0) begin
                check_val("spurious_retire", 32'd1, 32'd0);
            end else begin
                check_val("pc_on_retire", {26'd0, PC}, {26'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; n_push = 0; n_ret = 0;
        seq_ops = '{5'h00, 5'h0F, 5'h15, 5'h1E};
        rst = 1'b1; stall = 1'b0; literal = '0; Zflag = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_pc", {26'd0, PC}, 32'd0);
        check_val("rst_phase", {30'd0, phase}, 32'd0);
        check_val("rst_retire", {31'd0, retire}, 32'd0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_stk_err", {30'd0, stk_err}, 32'd0);

        for (int i = 0; i < 64; i++) begin
            exec(seq_ops[i % 4], 6'($urandom()), 1'($urandom()), 1'($urandom()));
        end
        check_val("pc_wrap_to_0", {26'd0, PC}, 32'd0);

        exec(OP_BZ, 6'h2A, 1'b1, 1'b0);
        check_val("bz_taken", {26'd0, PC}, 32'h2A);
        exec(OP_BZ, 6'h05, 1'b0, 1'b1);
        check_val("bz_not_taken", {26'd0, PC}, 32'h2B);
        exec(OP_BNZ, 6'h30, 1'b1, 1'b0);
        check_val("bnz_not_taken", {26'd0, PC}, 32'h2C);
        exec(OP_BNZ, 6'h30, 1'b0, 1'b1);
        check_val("bnz_taken", {26'd0, PC}, 32'h30);
        exec(OP_BRA, 6'h05, 1'b0, 1'b0);
        check_val("bra", {26'd0, PC}, 32'h05);

        exec(OP_CALL, 6'h10, 1'b0, 1'b0);
        check_val("call_target", {26'd0, PC}, 32'h10);
        exec(OP_RET, 6'h3F, 1'b0, 1'b0);
        check_val("ret_return", {26'd0, PC}, 32'h06);
        check_val("call_ret_no_err", {30'd0, stk_err}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            exec(OP_CALL, 6'h20 + 6'(i), 1'b0, 1'b0);
        end
        check_val("overflow_pc", {26'd0, PC}, 32'h24);
        check_val("overflow_flag", {30'd0, stk_err}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            exec(OP_RET, 6'(i), 1'b0, 1'b0);
            check_val("ret_chain_err", {30'd0, stk_err}, {30'd0, exp_err});
        end
        check_val("underflow_pc", {26'd0, PC}, 32'h08);
        check_val("underflow_flag", {30'd0, stk_err}, 32'h3);

        // Stall at phase 1 for four cycles; a BZ with Zflag low at capture falls through.
        pc_before = exp_pc;
        literal = make_lit(OP_BZ, 6'h15);
        model_step(OP_BZ, 6'h15, 1'b0);
        sb_q.push_back(exp_pc);
        n_push++;
        Zflag = 1'b1;
        @(posedge clk); #1;
        check_val("stall_entry_phase", {30'd0, phase}, 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_val("stall_phase", {30'd0, phase}, 32'd1);
            check_val("stall_pc", {26'd0, PC}, {26'd0, pc_before});
            check_val("stall_retire", {31'd0, retire}, 32'd0);
        end
        stall = 1'b0; Zflag = 1'b0;
        @(posedge clk); #1;
        Zflag = 1'b1;
        check_val("stall_cycle6_pc", {26'd0, PC}, {26'd0, pc_before});
        @(posedge clk); #1;
        check_val("stall_cycle7_pc", {26'd0, PC}, 32'h09);
        check_val("stall_cycle7_retire", {31'd0, retire}, 32'd1);

        exec(OP_HALT, 6'h00, 1'b0, 1'b0);
        check_val("halt_set", {31'd0, halted}, 32'd1);
        check_val("halt_phase", {30'd0, phase}, 32'd2);
        for (int i = 0; i < 6; i++) begin
            literal = make_lit(OP_CALL, 6'($urandom()));
            Zflag = 1'($urandom());
            @(posedge clk); #1;
            check_val("halt_pc_hold", {26'd0, PC}, 32'h09);
            check_val("halt_sticky", {31'd0, halted}, 32'd1);
            check_val("halt_no_retire", {31'd0, retire}, 32'd0);
            check_val("halt_phase_frozen", {30'd0, phase}, 32'd2);
        end
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_val("post_halt_rst_pc", {26'd0, PC}, 32'd0);
        check_val("post_halt_rst_phase", {30'd0, phase}, 32'd0);
        check_val("post_halt_rst_halted", {31'd0, halted}, 32'd0);
        check_val("post_halt_rst_err", {30'd0, stk_err}, 32'd0);

        // Abandon a BRA in flight with rst asserted together with stall.
        literal = make_lit(OP_BRA, 6'h3F);
        Zflag = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0;
        check_val("midrst_pc", {26'd0, PC}, 32'd0);
        check_val("midrst_phase", {30'd0, phase}, 32'd0);
        check_val("midrst_retire", {31'd0, retire}, 32'd0);
        exec(5'h03, 6'h11, 1'b1, 1'b0);
        check_val("after_midrst_pc", {26'd0, PC}, 32'd1);

        @(posedge clk); #1;
        check_val("sb_drained", sb_q.size(), 32'd0);
        check_val("retire_count", n_ret, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter PC_W, default 6: program counter width in bits.
REQ-003 Parameter INSTR_W, default 49: instruction word width; opcode is literal[INSTR_W-1:INSTR_W-5]; branch target is literal[PC_W-1:0].
REQ-004 Parameter STAGES, default 3: clocks per instruction (>=2); the Z sample phase is fixed at 1.
REQ-005 Parameter DEPTH, default 4: return-stack entries (power of 2, >=2).
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 stall  in  1  when high, freezes the phase counter and all state.
REQ-009 literal  in  INSTR_W  current instruction.
REQ-010 Zflag  in  1  ALU zero flag.
REQ-011 PC  out  PC_W  registered program counter.
REQ-012 phase  out  clog2(STAGES)  current phase, 0..STAGES-1.
REQ-013 retire  out  1  registered; high for exactly the one cycle after each PC update.
REQ-014 halted  out  1  sticky halt indication.
REQ-015 stk_err  out  2  sticky flags: bit0 overflow, bit1 underflow.

Function
REQ-016 Opcodes SHALL be: BZ=5'h10, BNZ=5'h11, BRA=5'h12, CALL=5'h13, RET=5'h14, HALT=5'h1F. All other opcodes are sequential.
REQ-017 phase SHALL advance by 1 per unstalled cycle while not halted, and SHALL wrap from STAGES-1 to 0.
REQ-018 On an unstalled cycle with phase==1, Zflag SHALL be captured into z_q; no other phase captures Zflag.
REQ-019 The PC update SHALL occur only on an unstalled, non-halted cycle with phase==STAGES-1, giving one instruction per STAGES unstalled cycles.
REQ-020 Sequential / default: PC <= PC+1, wrapping modulo 2^PC_W (all-ones -> 0).
REQ-021 BZ: PC <= target if z_q=1, else PC+1. BNZ: PC <= PC+1 if z_q=1, else target. BRA: PC <= target.
REQ-022 CALL, stack not full: push PC+1 (wrapped) and set PC <= target. CALL, stack full: no push, set stk_err[0], PC <= PC+1.
REQ-023 RET, stack not empty: pop and set PC <= popped value. RET, stack empty: set stk_err[1], PC <= PC+1.
REQ-024 HALT: PC SHALL hold, halted <= 1, and phase SHALL freeze at STAGES-1; only rst clears halted.
REQ-025 stall SHALL take priority: a stalled cycle changes no register, and retire is 0 in the cycle that follows it.
REQ-026 The stack SHALL be LIFO with an occupancy count of 0..DEPTH; full = count==DEPTH and empty = count==0.
REQ-027 Overflow and underflow SHALL never corrupt stack contents or count.
REQ-028 retire SHALL also pulse on the HALT update cycle, and SHALL stay 0 while halted.
REQ-029 stk_err bits SHALL be sticky until reset; an error does not halt the block.

Reset
REQ-030 rst has priority over stall. It sets PC=0, phase=0, z_q=0, retire=0, halted=0, stk_err=0, and stack count=0. Stack entry contents are don't-care.
REQ-031 Reset asserted mid-instruction SHALL abandon that instruction; counting restarts from phase 0 in the cycle after rst deasserts.

Verification
REQ-032 Sequential program, no stall -> PC steps 0,1,2,... every 3 cycles; retire is high one cycle per step; PC wraps 63 -> 0.
REQ-033 BZ target 6'h2A with Zflag=1 at phase 1 and Zflag=0 at phase 2 -> PC=0x2A; the same with Zflag=0 at phase 1 -> PC+1.
REQ-034 CALL 0x10 at PC=5, then RET -> PC=0x10, then PC=6; stack count returns to 0.
REQ-035 Five nested CALLs (DEPTH=4) -> the 5th sets stk_err=2'b01 and PC advances by 1; then 5 RETs -> 4 correct returns, the 5th sets stk_err=2'b11.
REQ-036 stall held 4 cycles at phase 1 -> phase, PC and z_q are unchanged, and the total instruction time is 7 cycles.
REQ-037 HALT at PC=9, then rst pulse at an arbitrary later cycle -> PC holds at 9 with halted=1 until reset, then PC=0, phase=0, halted=0.
